serial_adder: RTL and testbench

SERIAL_ADDER -- requirements
Module: serial_adder

---
 rtl/serial_adder.sv | 98 +++++++++
 tb/tb_serial_adder.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial LSB-first adder: one full-adder bit per clock, IDLE/ADD/DONE control.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic ha0_s, ha0_c, ha1_s, ha1_c, fa_c;

  // Full adder from two half adders; carry_q doubles as the visible carry-out.
  always_comb begin
    ha0_s = a_q[0] ^ b_q[0];
    ha0_c = a_q[0] & b_q[0];
    ha1_s = ha0_s ^ carry_q;
    ha1_c = ha0_s & carry_q;
    fa_c  = ha0_c | ha1_c;
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = A;
          b_d     = B;
          sum_d   = '0;
          carry_d = 1'b0;
          cnt_d   = '0;
          state_d = ADD;
        end
      end
      ADD: begin
        sum_d   = {ha1_s, sum_q[WIDTH-1:1]};
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        carry_d = fa_c;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy  = (state_q == ADD);
  assign done  = (state_q == DONE);
  assign sum   = sum_q;
  assign carry = carry_q;

endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - directed bench for serial_adder with a cycle-phase reference model.
module tb_serial_adder;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic         busy, done, carry;
  logic [W-1:0] sum;

  int vectors = 0;
  int fails   = 0;

  serial_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .A     (A),
    .B     (B),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .carry (carry)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at t=%0t: got %h want %h", name, $time, act, exp);
    end
  endtask

  // Model: ph counts cycles since the accepting edge (0 = idle, 1..W busy, W+1 done).
  int           ph = 0;
  logic [W:0]   res_exp = '0;
  logic [W-1:0] a_m = '0, b_m = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ph      = 0;
      res_exp = '0;
    end else if (ph == 0) begin
      if (start) begin
        ph      = 1;
        a_m     = A;
        b_m     = B;
        res_exp = {1'b0, A} + {1'b0, B};
      end
    end else if (ph == W + 1) begin
      ph = 0;
    end else begin
      ph++;
    end
  end

  always @(negedge clk) begin
    chk("busy", 32'(busy), 32'(ph >= 1 && ph <= W));
    chk("done", 32'(done), 32'(ph == W + 1));
    if (ph == 0 || ph == W + 1)
      chk("result", 32'({carry, sum}), 32'(res_exp));
    if (done)
      $display("t=%0t A=%h B=%h sum=%h carry=%b", $time, a_m, b_m, sum, carry);
  end

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] es, input logic ec);
    int n;
    @(negedge clk);
    A = a; B = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 1;
    while (!done && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("latency", 32'(n), 32'(9));
    chk("sum_lit", 32'(sum), 32'(es));
    chk("carry_lit", 32'(carry), 32'(ec));
  endtask

  initial begin
    int dn;
    int last_t;
    #1;
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_done", 32'(done), 32'(0));
    chk("rst_sum", 32'(sum), 32'(0));
    chk("rst_carry", 32'(carry), 32'(0));
    start = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    start = 1'b0;

    run_op(8'h05, 8'h03, 8'h08, 1'b0);
    run_op(8'hFF, 8'h01, 8'h00, 1'b1);
    run_op(8'hFF, 8'hFF, 8'hFE, 1'b1);
    run_op(8'h00, 8'h00, 8'h00, 1'b0);

    // Re-pulse start and change operands while the addition is in flight.
    @(negedge clk);
    A = 8'h12; B = 8'h34; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    A = 8'hAA; B = 8'h55; start = 1'b1;
    @(negedge clk);
    start = 1'b0; A = 8'h01; B = 8'h02;
    dn = 0;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      if (done) begin
        dn++;
        chk("inflight_sum", 32'(sum), 32'h46);
        chk("inflight_carry", 32'(carry), 32'(0));
      end
    end
    chk("inflight_one_done", 32'(dn), 32'(1));

    // Abort in the 4th ADD cycle; outputs must clear before any clock edge.
    @(negedge clk);
    A = 8'h33; B = 8'h44; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("abort_busy", 32'(busy), 32'(0));
    chk("abort_done", 32'(done), 32'(0));
    chk("abort_sum", 32'(sum), 32'(0));
    chk("abort_carry", 32'(carry), 32'(0));
    start = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    start = 1'b0;
    dn = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done) dn++;
    end
    chk("abort_no_done", 32'(dn), 32'(0));
    run_op(8'h0A, 8'h0B, 8'h15, 1'b0);

    // start held high: back-to-back operations every W+2 cycles.
    @(negedge clk);
    A = 8'h80; B = 8'h80; start = 1'b1;
    dn = 0;
    last_t = -1;
    for (int i = 0; i < 36; i++) begin
      if (i == 25) start = 1'b0;
      if (done) begin
        if (last_t >= 0) chk("b2b_period", 32'(i - last_t), 32'(10));
        chk("b2b_sum", 32'(sum), 32'h00);
        chk("b2b_carry", 32'(carry), 32'(1));
        last_t = i;
        dn++;
      end
      @(negedge clk);
    end
    chk("b2b_count", 32'(dn), 32'(3));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

endmodule
